bicubic_window_issuer: RTL and testbench

//  Requester side of the bicubic upsampler: builds 4x4 source windows from a stream of 4-pixel

---
 rtl/bicubic_window_issuer.sv | 179 +++++++++++++++++
 tb/tb_bicubic_window_issuer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_window_issuer.sv
// Builds 4x4 bicubic source windows from a column stream (edge-replicated) and forwards response beats.
// Latency: window valid 1 cycle after the completing column or pad shift; response beats pass through combinationally.
// Backpressure: out_ready stalls response beats (window and beat index held); col_ready low while padding or issuing.
module bicubic_window_issuer #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       col_valid,
    output logic                       col_ready,
    input  logic [4*CHANNEL_WIDTH-1:0] col_data,
    input  logic                       col_last,
    output logic                       bf_req_valid,
    input  logic                       bcci_req_ready,
    output logic [CHANNEL_WIDTH-1:0]   p1,
    output logic [CHANNEL_WIDTH-1:0]   p2,
    output logic [CHANNEL_WIDTH-1:0]   p3,
    output logic [CHANNEL_WIDTH-1:0]   p4,
    output logic [CHANNEL_WIDTH-1:0]   p5,
    output logic [CHANNEL_WIDTH-1:0]   p6,
    output logic [CHANNEL_WIDTH-1:0]   p7,
    output logic [CHANNEL_WIDTH-1:0]   p8,
    output logic [CHANNEL_WIDTH-1:0]   p9,
    output logic [CHANNEL_WIDTH-1:0]   p10,
    output logic [CHANNEL_WIDTH-1:0]   p11,
    output logic [CHANNEL_WIDTH-1:0]   p12,
    output logic [CHANNEL_WIDTH-1:0]   p13,
    output logic [CHANNEL_WIDTH-1:0]   p14,
    output logic [CHANNEL_WIDTH-1:0]   p15,
    output logic [CHANNEL_WIDTH-1:0]   p16,
    input  logic                       bcci_rsp_valid,
    input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data1,
    input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data2,
    input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data3,
    input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data4,
    output logic                       bf_rsp_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4*CHANNEL_WIDTH-1:0] out_data,
    output logic [1:0]                 out_beat,
    output logic                       out_eol
);
    localparam int CW = CHANNEL_WIDTH;

    typedef enum logic [1:0] {S_LOAD, S_FILL, S_PAD, S_ISSUE} state_t;

    state_t          state_q;
    logic [4*CW-1:0] c0_q, c1_q, c2_q, c3_q;
    logic [1:0]      sc_q, repl_left_q, beat_q;
    logic            last_seen_q;
    logic            col_ready_q, req_valid_q;

    logic            col_hsk, rsp_hsk;
    logic [1:0]      sc_inc;

    // The request handshake always coincides with the first response beat, so only the beats are tracked.
    logic            unused_req_ready;
    assign unused_req_ready = bcci_req_ready;

    assign col_hsk = col_valid & col_ready_q;
    assign rsp_hsk = bcci_rsp_valid & out_ready & (state_q == S_ISSUE);
    assign sc_inc  = (sc_q == 2'd2) ? 2'd2 : sc_q + 2'd1;

    // Window FSM: column shifting, edge replication and beat counting with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            c0_q        <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
            c3_q        <= '0;
            sc_q        <= 2'd0;
            repl_left_q <= 2'd0;
            last_seen_q <= 1'b0;
            beat_q      <= 2'd0;
            col_ready_q <= 1'b1;
            req_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (col_hsk) begin
                        // First column of a row fills the whole window: left-edge replication.
                        c0_q        <= col_data;
                        c1_q        <= col_data;
                        c2_q        <= col_data;
                        c3_q        <= col_data;
                        sc_q        <= 2'd0;
                        last_seen_q <= col_last;
                        if (col_last) begin
                            repl_left_q <= 2'd2;
                            col_ready_q <= 1'b0;
                            state_q     <= S_PAD;
                        end else begin
                            state_q <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (col_hsk) begin
                        c0_q <= c1_q;
                        c1_q <= c2_q;
                        c2_q <= c3_q;
                        c3_q <= col_data;
                        sc_q <= sc_inc;
                        if (col_last) begin
                            last_seen_q <= 1'b1;
                            repl_left_q <= 2'd2;
                        end
                        if (sc_inc == 2'd2) begin
                            col_ready_q <= 1'b0;
                            req_valid_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end else if (col_last) begin
                            col_ready_q <= 1'b0;
                            state_q     <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    // Right-edge replication: re-shift the rightmost column.
                    c0_q        <= c1_q;
                    c1_q        <= c2_q;
                    c2_q        <= c3_q;
                    repl_left_q <= (repl_left_q != 2'd0) ? repl_left_q - 2'd1 : 2'd0;
                    sc_q        <= sc_inc;
                    if (sc_inc == 2'd2) begin
                        req_valid_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                default: begin
                    if (rsp_hsk) begin
                        beat_q <= beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            req_valid_q <= 1'b0;
                            if (last_seen_q && (repl_left_q != 2'd0)) begin
                                state_q <= S_PAD;
                            end else if (last_seen_q) begin
                                last_seen_q <= 1'b0;
                                col_ready_q <= 1'b1;
                                state_q     <= S_LOAD;
                            end else begin
                                col_ready_q <= 1'b1;
                                state_q     <= S_FILL;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign col_ready    = col_ready_q;
    assign bf_req_valid = req_valid_q;

    // p(4r+c+1) is source row r of window column c.
    assign p1  = c0_q[0*CW +: CW];
    assign p2  = c1_q[0*CW +: CW];
    assign p3  = c2_q[0*CW +: CW];
    assign p4  = c3_q[0*CW +: CW];
    assign p5  = c0_q[1*CW +: CW];
    assign p6  = c1_q[1*CW +: CW];
    assign p7  = c2_q[1*CW +: CW];
    assign p8  = c3_q[1*CW +: CW];
    assign p9  = c0_q[2*CW +: CW];
    assign p10 = c1_q[2*CW +: CW];
    assign p11 = c2_q[2*CW +: CW];
    assign p12 = c3_q[2*CW +: CW];
    assign p13 = c0_q[3*CW +: CW];
    assign p14 = c1_q[3*CW +: CW];
    assign p15 = c2_q[3*CW +: CW];
    assign p16 = c3_q[3*CW +: CW];

    assign bf_rsp_ready = out_ready;
    assign out_valid    = bcci_rsp_valid & (state_q == S_ISSUE);
    assign out_data     = {bcci_rsp_data4, bcci_rsp_data3, bcci_rsp_data2, bcci_rsp_data1};
    assign out_beat     = beat_q;
    assign out_eol      = out_valid & (beat_q == 2'd3) & last_seen_q & (repl_left_q == 2'd0);
endmodule

// File: tb/tb_bicubic_window_issuer.sv
module tb_bicubic_window_issuer;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    logic col_valid, col_ready, col_last;
    logic [4*CW-1:0] col_data;
    logic bf_req_valid, bcci_req_ready;
    logic [CW-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9, p10, p11, p12, p13, p14, p15, p16;
    logic bcci_rsp_valid;
    logic [CW-1:0] d1, d2, d3, d4;
    logic bf_rsp_ready, out_valid, out_ready, out_eol;
    logic [4*CW-1:0] out_data;
    logic [1:0] out_beat;

    always #5 clk = ~clk;

    bicubic_window_issuer #(.CHANNEL_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data), .col_last(col_last),
        .bf_req_valid(bf_req_valid), .bcci_req_ready(bcci_req_ready),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
        .p9(p9), .p10(p10), .p11(p11), .p12(p12), .p13(p13), .p14(p14), .p15(p15), .p16(p16),
        .bcci_rsp_valid(bcci_rsp_valid),
        .bcci_rsp_data1(d1), .bcci_rsp_data2(d2), .bcci_rsp_data3(d3), .bcci_rsp_data4(d4),
        .bf_rsp_ready(bf_rsp_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_beat(out_beat), .out_eol(out_eol)
    );

    typedef struct {
        logic [4*CW-1:0] dat;
        bit              last;
    } col_t;

    typedef struct {
        logic [16*CW-1:0] pix;
        bit               eol;
    } win_t;

    col_t            colq[$];
    win_t            expq[$];
    logic [4*CW-1:0] rowbuf[$];

    int n_checks = 0;
    int n_pass   = 0;
    int mbeat    = 0;
    int win_done = 0;
    int eol_seen = 0;
    bit col_acc  = 0;
    int col_pct  = 100;
    int rsp_pct  = 100;
    int rdy_pct  = 100;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: window x of a W-column row uses columns x-1..x+2 clamped to [0,W-1].
    task automatic push_row();
        int w;
        w = rowbuf.size();
        for (int i = 0; i < w; i++) begin
            col_t cc;
            cc.dat  = rowbuf[i];
            cc.last = (i == w - 1);
            colq.push_back(cc);
        end
        for (int x = 0; x < w; x++) begin
            win_t wn;
            wn.pix = '0;
            for (int c = 0; c < 4; c++) begin
                int k;
                k = x - 1 + c;
                if (k < 0) k = 0;
                if (k > w - 1) k = w - 1;
                for (int r = 0; r < 4; r++)
                    wn.pix[(4*r + c)*CW +: CW] = rowbuf[k][r*CW +: CW];
            end
            wn.eol = (x == w - 1);
            expq.push_back(wn);
        end
        rowbuf.delete();
    endtask

    function automatic logic [4*CW-1:0] splat(input int v);
        logic [CW-1:0] b;
        b = v[CW-1:0];
        return {b, b, b, b};
    endfunction

    task automatic step();
        logic [16*CW-1:0] pv;
        @(negedge clk);
        if (col_acc) begin
            col_valid = 1'b0;
            col_acc   = 1'b0;
        end
        if (!col_valid && colq.size() > 0 && $urandom_range(99) < col_pct) begin
            col_valid = 1'b1;
            col_data  = colq[0].dat;
            col_last  = colq[0].last;
        end
        bcci_rsp_valid = ($urandom_range(99) < rsp_pct);
        d1 = CW'($urandom); d2 = CW'($urandom); d3 = CW'($urandom); d4 = CW'($urandom);
        out_ready = ($urandom_range(99) < rdy_pct);
        #1;
        pv = {p16, p15, p14, p13, p12, p11, p10, p9, p8, p7, p6, p5, p4, p3, p2, p1};
        if (mbeat != 0) chk("req_held", bf_req_valid, 1'b1);
        if (bf_req_valid) begin
            if (expq.size() == 0) chk("req_spurious", 1'b1, 1'b0);
            else chk("window", pv, expq[0].pix);
        end
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk("beat_spurious", 1'b1, 1'b0);
            end else begin
                chk("out_beat", out_beat, mbeat[1:0]);
                chk("out_data", out_data, {d4, d3, d2, d1});
                chk("out_eol", out_eol, (mbeat == 3) && expq[0].eol);
                if (out_eol) eol_seen++;
                mbeat++;
                if (mbeat == 4) begin
                    mbeat = 0;
                    void'(expq.pop_front());
                    win_done++;
                end
            end
        end
        if (col_valid && col_ready) begin
            void'(colq.pop_front());
            col_acc = 1'b1;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4000 && (expq.size() > 0 || colq.size() > 0); i++) step();
        chk(tag, expq.size() + colq.size(), 0);
    endtask

    initial begin
        int base, eol0;
        rst = 1'b1;
        col_valid = 1'b0; col_data = '0; col_last = 1'b0;
        bcci_req_ready = 1'b1; bcci_rsp_valid = 1'b0;
        d1 = '0; d2 = '0; d3 = '0; d4 = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bcci_rsp_valid = 1'b1;
        #1;
        chk("rst_col_ready", col_ready, 1'b1);
        chk("rst_req_valid", bf_req_valid, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_eol", out_eol, 1'b0);
        chk("rst_beat", out_beat, 2'd0);
        chk("rst_pix", {p16, p15, p14, p13, p12, p11, p10, p9, p8, p7, p6, p5, p4, p3, p2, p1}, '0);

        // Directed rows: W=4, W=1, W=2 with everything ready.
        rowbuf.push_back(splat(10)); rowbuf.push_back(splat(20));
        rowbuf.push_back(splat(30)); rowbuf.push_back(splat(40));
        push_row();
        rowbuf.push_back(splat(55));
        push_row();
        rowbuf.push_back(splat(1)); rowbuf.push_back(splat(2));
        push_row();
        eol0 = eol_seen;
        drain("drain_directed");
        chk("eol_directed", eol_seen - eol0, 3);

        // Random rows with random gaps and stalls.
        col_pct = 60; rsp_pct = 70; rdy_pct = 50;
        for (int r = 0; r < 10; r++) begin
            int w;
            w = $urandom_range(1, 6);
            for (int i = 0; i < w; i++) rowbuf.push_back($urandom);
            push_row();
        end
        drain("drain_random");

        // Back-to-back W=3 rows with col_valid kept high.
        col_pct = 100; rsp_pct = 100; rdy_pct = 100;
        eol0 = eol_seen;
        base = win_done;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) rowbuf.push_back($urandom);
            push_row();
        end
        drain("drain_b2b");
        chk("b2b_windows", win_done - base, 6);
        chk("b2b_eol", eol_seen - eol0, 2);

        // Reset while beat 2 of the second window is presented.
        rdy_pct = 70;
        for (int i = 0; i < 4; i++) rowbuf.push_back($urandom);
        push_row();
        base = win_done;
        for (int i = 0; i < 2000 && !(win_done == base + 1 && mbeat == 2); i++) step();
        chk("rst_reach", (win_done == base + 1 && mbeat == 2), 1'b1);
        @(negedge clk);
        rst = 1'b1; col_valid = 1'b0; col_acc = 1'b0;
        bcci_rsp_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_req_valid", bf_req_valid, 1'b0);
        chk("midrst_col_ready", col_ready, 1'b1);
        chk("midrst_beat", out_beat, 2'd0);
        chk("midrst_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        colq.delete();
        expq.delete();
        mbeat = 0;
        for (int i = 0; i < 5; i++) rowbuf.push_back($urandom);
        push_row();
        drain("drain_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
